// File: rtl/zmod_prbs_checker_if.sv
// Purpose : receive-lane bundle into the PRBS-7 checker, plus its status/counter readback.
// Latency : n/a (signal bundle only).
// Backpressure: none; din_valid qualifies data, the checker never stalls the receive path.
//
// Ports
//   din        receive lanes -> checker, one bit per lane per valid cycle
//   din_valid  qualifies din; checker holds all state while low
//   clear      single-cycle pulse, zeroes counters and sticky flags
//   locked     per-lane lock status
//   los        sticky per-lane loss-of-lock flag
//   err_count  per-lane saturating error counters, lane i at [i*CNT_W +: CNT_W]
//   bit_count  saturating count of valid cycles since reset or clear
interface zmod_prbs_checker_if #(
   parameter int NLANES = 4,
   parameter int CNT_W  = 32
) ();

   logic [NLANES-1:0]       din;
   logic                    din_valid;
   logic                    clear;
   logic [NLANES-1:0]       locked;
   logic [NLANES-1:0]       los;
   logic [NLANES*CNT_W-1:0] err_count;
   logic [CNT_W-1:0]        bit_count;

   // Receive side / register file side.
   modport master (
      output din, din_valid, clear,
      input  locked, los, err_count, bit_count
   );

   // The checker itself.
   modport slave (
      input  din, din_valid, clear,
      output locked, los, err_count, bit_count
   );

endinterface

// File: rtl/zmod_prbs_checker.sv
// Purpose : independent per-lane PRBS-7 (x^7+x^6+1) checker: lock, error counts, loss-of-lock.
// Latency : all outputs registered; updated on the edge sampling the relevant valid bit.
// Backpressure: none; din_valid low freezes every state element and output.
//
// Ports
//   clk      receive clock, all logic on rising edge
//   aresetn  asynchronous active-low reset, clears all state and outputs immediately
//   bus      zmod_prbs_checker_if.slave: din/din_valid/clear in, locked/los/err_count/bit_count out
module zmod_prbs_checker #(
   parameter int NLANES     = 4,
   parameter int CNT_W      = 32,
   parameter int LOCK_LEN   = 32,
   parameter int WIN_LEN    = 64,
   parameter int LOS_THRESH = 8
) (
   input  logic                 clk,
   input  logic                 aresetn,
   zmod_prbs_checker_if.slave   bus
);

   localparam int GR_W = $clog2(LOCK_LEN + 1);
   localparam int WC_W = $clog2(WIN_LEN + 1);
   localparam int WE_W = $clog2(LOS_THRESH + 1);

   localparam logic [GR_W-1:0] RUN_LAST  = GR_W'(LOCK_LEN - 1);
   localparam logic [WC_W-1:0] WIN_LAST  = WC_W'(WIN_LEN - 1);
   localparam logic [WE_W-1:0] WERR_MAX  = WE_W'(LOS_THRESH);
   localparam logic [2:0]      SEED_LAST = 3'd6;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } lane_st_e;

   logic [NLANES-1:0]       locked_vec;
   logic [NLANES-1:0]       los_vec;
   logic [NLANES*CNT_W-1:0] err_vec;

   // ------------------------------------------------------------------
   // Per-lane checker
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NLANES; i++) begin : g_lane

      lane_st_e         st_q, st_d;
      logic [6:0]       lfsr_q, lfsr_d;
      logic [2:0]       seed_q, seed_d;
      logic [GR_W-1:0]  run_q, run_d;
      logic [WC_W-1:0]  wcnt_q, wcnt_d;
      logic [WE_W-1:0]  werr_q, werr_d;
      logic             locked_q, locked_d;
      logic             los_q, los_d;
      logic [CNT_W-1:0] err_q, err_d;

      logic             bit_in;
      logic             pred;
      logic             match;
      logic             err_hit;
      logic             loss_evt;
      logic [WE_W-1:0]  werr_nxt;

      assign bit_in = bus.din[i];
      assign pred   = lfsr_q[6] ^ lfsr_q[5];

      always_ff @(posedge clk or negedge aresetn) begin
         if (!aresetn) begin
            st_q     <= ST_SEED;
            lfsr_q   <= '0;
            seed_q   <= '0;
            run_q    <= '0;
            wcnt_q   <= '0;
            werr_q   <= '0;
            locked_q <= 1'b0;
            los_q    <= 1'b0;
            err_q    <= '0;
         end else begin
            st_q     <= st_d;
            lfsr_q   <= lfsr_d;
            seed_q   <= seed_d;
            run_q    <= run_d;
            wcnt_q   <= wcnt_d;
            werr_q   <= werr_d;
            locked_q <= locked_d;
            los_q    <= los_d;
            err_q    <= err_d;
         end
      end

      always_comb begin
         st_d     = st_q;
         lfsr_d   = lfsr_q;
         seed_d   = seed_q;
         run_d    = run_q;
         wcnt_d   = wcnt_q;
         werr_d   = werr_q;
         locked_d = locked_q;
         match    = 1'b0;
         err_hit  = 1'b0;
         loss_evt = 1'b0;
         werr_nxt = werr_q;

         if (bus.din_valid) begin
            case (st_q)
               ST_SEED: begin
                  lfsr_d = {lfsr_q[5:0], bit_in};
                  if (seed_q == SEED_LAST) begin
                     st_d   = ST_CHECK;
                     seed_d = '0;
                     run_d  = '0;
                  end else begin
                     seed_d = seed_q + 3'd1;
                  end
               end

               ST_CHECK: begin
                  lfsr_d = {lfsr_q[5:0], bit_in};
                  // All-zero state is the LFSR's dead state; treating it as a
                  // mismatch keeps stuck-at-0 lanes from ever locking.
                  match  = (bit_in == pred) && (lfsr_q != 7'd0);
                  if (match) begin
                     if (run_q == RUN_LAST) begin
                        st_d     = ST_LOCKED;
                        locked_d = 1'b1;
                        run_d    = '0;
                        wcnt_d   = '0;
                        werr_d   = '0;
                     end else begin
                        run_d = run_q + GR_W'(1);
                     end
                  end else begin
                     run_d = '0;
                  end
               end

               ST_LOCKED: begin
                  // Free-run on the prediction so one flipped bit is one error,
                  // not a burst of follow-on mispredictions.
                  lfsr_d  = {lfsr_q[5:0], pred};
                  err_hit = (bit_in != pred);
                  if (err_hit && (werr_q != WERR_MAX)) begin
                     werr_nxt = werr_q + WE_W'(1);
                  end
                  if (wcnt_q == WIN_LAST) begin
                     // Window closes on this bit; its error already counts.
                     wcnt_d = '0;
                     werr_d = '0;
                     if (werr_nxt >= WERR_MAX) begin
                        st_d     = ST_SEED;
                        seed_d   = '0;
                        locked_d = 1'b0;
                        loss_evt = 1'b1;
                     end
                  end else begin
                     wcnt_d = wcnt_q + WC_W'(1);
                     werr_d = werr_nxt;
                  end
               end

               default: begin
                  st_d = ST_SEED;
               end
            endcase
         end
      end

      // clear wins over a coincident error; a coincident loss event wins over clear for los.
      always_comb begin
         err_d = err_q;
         if (bus.clear) begin
            err_d = '0;
         end else if (err_hit && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
         end
      end

      always_comb begin
         los_d = los_q;
         if (loss_evt) begin
            los_d = 1'b1;
         end else if (bus.clear) begin
            los_d = 1'b0;
         end
      end

      assign locked_vec[i]                = locked_q;
      assign los_vec[i]                   = los_q;
      assign err_vec[i*CNT_W +: CNT_W]    = err_q;

   end : g_lane

   // ------------------------------------------------------------------
   // Shared valid-bit counter
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (bus.clear) begin
         bit_cnt_d = '0;
      end else if (bus.din_valid && (bit_cnt_q != '1)) begin
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         bit_cnt_q <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bus.locked    = locked_vec;
   assign bus.los       = los_vec;
   assign bus.err_count = err_vec;
   assign bus.bit_count = bit_cnt_q;

endmodule

// File: tb/tb_zmod_prbs_checker.sv
// Purpose : self-checking bench for zmod_prbs_checker against a bit-sequence reference model.
// Latency : model predicts post-edge outputs; DUT sampled on the falling edge.
// Backpressure: n/a; bench drives din_valid gaps directly.
module tb_zmod_prbs_checker;

   localparam int NL         = 4;
   localparam int CW         = 32;
   localparam int LOCK_LEN   = 32;
   localparam int WIN_LEN    = 64;
   localparam int LOS_THRESH = 8;
   localparam longint MAXC   = (64'd1 << CW) - 1;

   logic clk     = 1'b0;
   logic aresetn = 1'b0;

   always #5 clk = ~clk;

   zmod_prbs_checker_if #(.NLANES(NL), .CNT_W(CW)) bus_if ();

   zmod_prbs_checker #(
      .NLANES(NL), .CNT_W(CW), .LOCK_LEN(LOCK_LEN),
      .WIN_LEN(WIN_LEN), .LOS_THRESH(LOS_THRESH)
   ) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus_if)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Each lane keeps the last 7 bits fed into its predictor (h[i][6] newest).
   // PRBS-7: the next bit equals the bits 7 and 6 positions back, XORed.
   int     ph    [NL];   // 0 seeding, 1 hunting, 2 locked
   int     seedn [NL];
   int     run   [NL];
   int     wc    [NL];
   int     we    [NL];
   bit     h     [NL][7];
   bit     m_lk  [NL];
   bit     m_los [NL];
   longint m_err [NL];
   longint m_bits;

   bit [6:0] gen [NL];   // stimulus generators

   task automatic model_reset();
      for (int i = 0; i < NL; i++) begin
         ph[i] = 0; seedn[i] = 0; run[i] = 0; wc[i] = 0; we[i] = 0;
         for (int k = 0; k < 7; k++) h[i][k] = 1'b0;
         m_lk[i] = 1'b0; m_los[i] = 1'b0; m_err[i] = 0;
      end
      m_bits = 0;
   endtask

   task automatic model_edge(input logic [NL-1:0] d, input logic v, input logic c);
      for (int i = 0; i < NL; i++) begin
         bit pred, allz, b, loss;
         int ones;
         loss = 1'b0;
         b    = d[i];
         pred = h[i][0] ^ h[i][1];
         ones = 0;
         for (int k = 0; k < 7; k++) ones += int'(h[i][k]);
         allz = (ones == 0);
         if (v) begin
            case (ph[i])
               0: begin
                  seedn[i]++;
                  if (seedn[i] == 7) begin ph[i] = 1; run[i] = 0; seedn[i] = 0; end
               end
               1: begin
                  if (d[i] == pred && !allz) run[i]++; else run[i] = 0;
                  if (run[i] == LOCK_LEN) begin
                     ph[i] = 2; m_lk[i] = 1'b1; wc[i] = 0; we[i] = 0; run[i] = 0;
                  end
               end
               default: begin
                  b = pred;
                  if (d[i] != pred) begin
                     we[i]++;
                     if (!c && m_err[i] < MAXC) m_err[i]++;
                  end
                  wc[i]++;
                  if (wc[i] == WIN_LEN) begin
                     if (we[i] >= LOS_THRESH) begin
                        ph[i] = 0; seedn[i] = 0; m_lk[i] = 1'b0; loss = 1'b1;
                     end
                     wc[i] = 0; we[i] = 0;
                  end
               end
            endcase
            for (int k = 0; k < 6; k++) h[i][k] = h[i][k+1];
            h[i][6] = b;
         end
         if (c) m_err[i] = 0;
         if (loss) m_los[i] = 1'b1;
         else if (c) m_los[i] = 1'b0;
      end
      if (c) m_bits = 0;
      else if (v && m_bits < MAXC) m_bits++;
   endtask

   task automatic chk_all();
      logic [NL-1:0] elk, elos;
      for (int i = 0; i < NL; i++) begin
         elk[i]  = m_lk[i];
         elos[i] = m_los[i];
      end
      chk("locked", 32'(bus_if.locked), 32'(elk));
      chk("los", 32'(bus_if.los), 32'(elos));
      for (int i = 0; i < NL; i++)
         chk($sformatf("err_count%0d", i), bus_if.err_count[i*CW +: CW], m_err[i][CW-1:0]);
      chk("bit_count", bus_if.bit_count, m_bits[CW-1:0]);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic gen_bits(output logic [NL-1:0] b);
      for (int i = 0; i < NL; i++) begin
         b[i]   = gen[i][6] ^ gen[i][5];
         gen[i] = {gen[i][5:0], b[i]};
      end
   endtask

   task automatic seed_all(input bit [6:0] s);
      for (int i = 0; i < NL; i++) gen[i] = s;
   endtask

   // Called at a falling edge; returns at the next falling edge after checking.
   task automatic step(input logic [NL-1:0] d, input logic v, input logic c);
      bus_if.din       = d;
      bus_if.din_valid = v;
      bus_if.clear     = c;
      model_edge(d, v, c);
      @(posedge clk);
      @(negedge clk);
      chk_all();
   endtask

   // Reset asserted between clock edges; outputs must clear without an edge.
   task automatic do_reset();
      @(negedge clk);
      #1;
      aresetn          = 1'b0;
      bus_if.din       = '0;
      bus_if.din_valid = 1'b0;
      bus_if.clear     = 1'b0;
      #1;
      model_reset();
      chk_all();
      @(negedge clk);
      aresetn = 1'b1;
   endtask

   task automatic clean_run(input int n);
      logic [NL-1:0] b;
      for (int k = 0; k < n; k++) begin
         gen_bits(b);
         step(b, 1'b1, 1'b0);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [NL-1:0] b;
      bus_if.din       = '0;
      bus_if.din_valid = 1'b0;
      bus_if.clear     = 1'b0;
      model_reset();

      // 1: clean PRBS, lock on valid bit 39
      do_reset();
      seed_all(7'h7F);
      for (int k = 1; k <= 39; k++) begin
         gen_bits(b);
         step(b, 1'b1, 1'b0);
         if (k == 38) chk("t1_prelock", 32'(bus_if.locked), 32'h0);
      end
      chk("t1_locked", 32'(bus_if.locked), 32'hF);
      chk("t1_bitcnt", bus_if.bit_count, 32'd39);

      // 2: single bit error on lane 2
      gen_bits(b);
      b[2] = ~b[2];
      step(b, 1'b1, 1'b0);
      chk("t2_err2", bus_if.err_count[2*CW +: CW], 32'd1);
      chk("t2_err0", bus_if.err_count[0 +: CW], 32'd0);
      chk("t2_locked", 32'(bus_if.locked), 32'hF);
      chk("t2_los", 32'(bus_if.los), 32'h0);
      clean_run(10);

      // 3: stuck lanes never lock
      do_reset();
      seed_all(7'h7F);
      for (int k = 0; k < 300; k++) begin
         gen_bits(b);
         b[0] = 1'b0;
         b[3] = 1'b1;
         step(b, 1'b1, 1'b0);
      end
      chk("t3_locked", 32'(bus_if.locked), 32'h6);

      // 4: one fully inverted window on lane 1 -> loss, then relock
      do_reset();
      seed_all(7'h7F);
      clean_run(39);
      for (int k = 0; k < WIN_LEN; k++) begin
         gen_bits(b);
         b[1] = ~b[1];
         step(b, 1'b1, 1'b0);
      end
      chk("t4_err1", bus_if.err_count[1*CW +: CW], 32'd64);
      chk("t4_los", 32'(bus_if.los), 32'h2);
      chk("t4_locked", 32'(bus_if.locked), 32'hD);
      clean_run(38);
      chk("t4_prerelock", 32'(bus_if.locked), 32'hD);
      clean_run(1);
      chk("t4_relock", 32'(bus_if.locked), 32'hF);
      chk("t4_los_sticky", 32'(bus_if.los), 32'h2);

      // 5: din_valid every other clock, garbage on idle cycles
      do_reset();
      seed_all(7'h7F);
      for (int k = 0; k < 78; k++) begin
         if (k % 2 == 1) begin
            gen_bits(b);
            step(b, 1'b1, 1'b0);
         end else begin
            step(NL'($urandom), 1'b0, 1'b0);
         end
      end
      chk("t5_locked", 32'(bus_if.locked), 32'hF);
      chk("t5_bitcnt", bus_if.bit_count, 32'd39);

      // 6a: clear coincident with a lane-0 error
      gen_bits(b);
      b[0] = ~b[0];
      step(b, 1'b1, 1'b1);
      chk("t6_err0", bus_if.err_count[0 +: CW], 32'd0);
      chk("t6_bitcnt", bus_if.bit_count, 32'd0);
      chk("t6_locked", 32'(bus_if.locked), 32'hF);

      // 6b: asynchronous reset while lanes are hunting
      do_reset();
      seed_all(7'h5A);
      clean_run(20);
      chk("t6_pre_rst_bits", bus_if.bit_count, 32'd20);
      do_reset();

      // Randomised: random seeds, valid gaps, error bursts and clears
      for (int i = 0; i < NL; i++) gen[i] = 7'($urandom_range(1, 127));
      begin
         int rate [NL];
         for (int k = 0; k < 3000; k++) begin
            logic v, c;
            if (k % 250 == 0)
               for (int i = 0; i < NL; i++) rate[i] = $urandom_range(0, 2);
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 149) == 0);
            if (v) begin
               gen_bits(b);
               for (int i = 0; i < NL; i++) begin
                  if (rate[i] == 1 && $urandom_range(0, 99) == 0) b[i] = ~b[i];
                  if (rate[i] == 2 && $urandom_range(0, 2) == 0)  b[i] = ~b[i];
               end
            end else begin
               b = NL'($urandom);
            end
            step(b, v, c);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/zmod_prbs_checker.md
Name: zmod_prbs_checker

Overview:
- Per-lane PRBS-7 checker for the ZMOD loopback link.
- Sits directly downstream of the ZMOD receive path. It consumes the 4 deserialised receive lanes (one bit per lane per clock, in the rxclk domain) and reports lock, error counts and loss-of-lock per lane.
- Counters and status are exported for software readback through the register file. CDC to the register-file clock happens outside this block.

Parameters:
- NLANES, 4: number of receive lanes checked independently.
- CNT_W, 32: width of per-lane error counters and of the bit counter.
- LOCK_LEN, 32: consecutive matching bits required in CHECK before declaring lock.
- WIN_LEN, 64: loss-of-lock observation window, in valid bits.
- LOS_THRESH, 8: errors within one window that force loss of lock.

Ports:
- clk  in  1  receive clock (rxclk domain); all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- din  in  NLANES  received bit per lane.
- din_valid  in  1  qualifies din; when low, all state and counters hold.
- clear  in  1  single-cycle pulse, synchronous to clk; zeroes counters and sticky flags.
- locked  out  NLANES  per-lane lock status.
- los  out  NLANES  sticky per-lane loss-of-lock flag.
- err_count  out  NLANES*CNT_W  per-lane error count, saturating; lane i occupies bits [i*CNT_W +: CNT_W].
- bit_count  out  CNT_W  number of din_valid cycles since reset or clear, saturating.

Behaviour:
- Reset:
  - All outputs are 0 while aresetn is low, and become 0 immediately on assertion.
  - Every lane enters SEED with LFSR state 0 and all internal counters 0.
- Polynomial: x^7+x^6+1, 7-bit state s[6:0].
  - Predicted bit p = s[6]^s[5].
  - Shift is s <= {s[5:0], b}, where b is the shifted-in bit.
- Per-lane FSM. States advance only on din_valid=1.
  - SEED: b=din[i]. A seed counter runs 0..6; on the 7th valid bit, go to CHECK with good_run=0.
  - CHECK: b=din[i].
    - Match is (din[i]==p) and (s != 0). The all-zero state is always a mismatch, so stuck-at-0 lanes never lock.
    - On match, good_run increments. On mismatch, good_run is set to 0.
    - When good_run reaches LOCK_LEN, go to LOCKED with win_cnt=0 and win_err=0.
  - LOCKED: b=p (free-running prediction), so a single bit error counts exactly once.
    - locked[i]=1, registered: asserted on the clock edge that sampled the LOCK_LEN-th matching bit.
    - On mismatch, err_count[i] and win_err increment. err_count saturates at all-ones; win_err saturates at LOS_THRESH.
    - win_cnt increments per valid bit.
    - When win_cnt reaches WIN_LEN, the window closes. An error on that last bit counts toward this window.
    - At window close, if win_err >= LOS_THRESH: go to SEED, set los[i]=1 (sticky), and deassert locked[i]. Otherwise reset win_cnt and win_err and stay in LOCKED.
- Lock latency: locked rises on the clock edge sampling the 39th valid bit of clean PRBS after SEED (7 seed bits + 32 matching bits).
- Counter latency: err_count updates on the edge sampling the erroneous bit. bit_count increments on every din_valid edge.
- clear:
  - Zeroes all err_count, bit_count and los on the next edge. FSM states, LFSRs and window counters are unaffected.
  - Precedence: clear beats a coincident error or valid bit, which are discarded from the counters.
  - If a loss-of-lock event coincides with clear, los is set, so the event wins over the clear for that flag.
- Lanes are fully independent; there is no cross-lane alignment.
- Hold: din_valid=0 for any duration changes no state and no output.

Test Plan:
1. Reset, then drive clean PRBS-7 (seed 7'h7F) on all lanes with din_valid=1 → locked=4'hF on the edge sampling valid bit 39; err_count all 0; bit_count=39 at that edge.
2. After lock, flip one bit on lane 2 → err_count lane 2 = 1, other lanes 0, locked stays 4'hF, los=0.
3. Lane 0 held at 0 and lane 3 held at 1 for 300 valid cycles, other lanes clean → locked=4'b0110; lanes 0 and 3 never lock.
4. After lock, invert lane 1 for the 64 bits following LOCKED entry, then restore PRBS → at window close err_count lane 1 = 64, los=4'b0010, locked[1]=0; relock 39 valid bits later with los still 1.
5. din_valid toggling every other clock with clean data → lock after 39 valid bits (78 clocks); bit_count=39.
6. Pulse clear on the same cycle as an injected lane-0 error → err_count lane 0 = 0, bit_count=0, locked unchanged. Then assert aresetn low mid-CHECK → all outputs 0 immediately, with no clock edge required.
